// File: rtl/nes_pad_scanner.sv
// Multi-channel NES/SNES pad scanner: one internal timebase drives SRL/SRCLK and all pads are captured in parallel.
// Optional automatic polling is built when NES_AUTOPOLL_EN is defined.

module nes_pad_lane #(
  parameter int BITS = 8
) (
  input  logic            CLK,
  input  logic            reset_n,
  input  logic            d,
  input  logic            sample,
  input  logic            load,
  output logic [BITS-1:0] q
);
  logic [1:0]      sync;
  logic [BITS-1:0] sr, sr_n;

  // Bits enter at the MSB and move toward the LSB, so the first bit sampled ends in bit 0.
  always_comb begin
    sr_n = sr;
    if (sample) begin
      sr_n = sr >> 1;
      sr_n[BITS-1] = ~sync[1];
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      sync <= '0;
      sr   <= '0;
      q    <= '0;
    end else begin
      sync <= {sync[0], d};
      sr   <= sr_n;
      if (load) q <= sr_n;
    end
  end
endmodule

module nes_pad_scanner #(
  parameter int CHANNELS = 2,
  parameter int BITS     = 8,
  parameter int HALF_DIV = 300,
  parameter int POLL_DIV = 833333
) (
  input  logic                     CLK,
  input  logic                     reset_n,
  input  logic                     en,
  input  logic                     start,
  input  logic [CHANNELS-1:0]      D,
  output logic                     SRL,
  output logic                     SRCLK,
  output logic [CHANNELS*BITS-1:0] buttons,
  output logic                     valid,
  output logic                     busy
);
  localparam int TW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam int BW = $clog2(BITS + 1);

  typedef enum logic [2:0] {IDLE, LATCH, CLK_HI, CLK_LO, DONE} state_t;

  state_t                        state, state_n;
  logic [TW-1:0]                 tick, tick_n;
  logic [BW-1:0]                 bitc, bitc_n;
  logic                          sample, load, tick_end, poll_trig;
  logic [CHANNELS-1:0][BITS-1:0] btn;

`ifdef NES_AUTOPOLL_EN
  localparam int PW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  logic [PW-1:0] poll_cnt;

  assign poll_trig = en && (poll_cnt == PW'(POLL_DIV - 1));

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n)  poll_cnt <= '0;
    else if (en)   poll_cnt <= poll_trig ? '0 : poll_cnt + 1'b1;
  end
`else
  assign poll_trig = 1'b0;
`endif

  assign tick_end = (tick == TW'(HALF_DIV - 1));

  always_comb begin
    state_n = state;
    tick_n  = tick;
    bitc_n  = bitc;
    sample  = 1'b0;
    load    = 1'b0;
    if (en) begin
      tick_n = tick_end ? '0 : tick + 1'b1;
      case (state)
        IDLE: begin
          tick_n = '0;
          if (start || poll_trig) begin
            state_n = LATCH;
            bitc_n  = '0;
          end
        end
        // LATCH spans two ticks; bitc counts them before it starts counting sampled bits.
        LATCH: if (tick_end) begin
          if (bitc == '0) bitc_n = BW'(1);
          else begin
            sample  = 1'b1;
            bitc_n  = BW'(1);
            state_n = (BITS > 1) ? CLK_HI : DONE;
          end
        end
        CLK_HI: if (tick_end) begin
          sample  = 1'b1;
          bitc_n  = bitc + 1'b1;
          state_n = CLK_LO;
        end
        CLK_LO: if (tick_end) state_n = (bitc < BW'(BITS)) ? CLK_HI : DONE;
        DONE: begin
          tick_n  = '0;
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
      load = (state_n == DONE) && (state != DONE);
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      tick  <= '0;
      bitc  <= '0;
      SRL   <= 1'b0;
      SRCLK <= 1'b0;
      valid <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      tick  <= tick_n;
      bitc  <= bitc_n;
      SRL   <= (state_n == LATCH);
      SRCLK <= (state_n == CLK_HI);
      valid <= load;
      busy  <= (state_n != IDLE);
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    nes_pad_lane #(.BITS(BITS)) u_lane (
      .CLK    (CLK),
      .reset_n(reset_n),
      .d      (D[c]),
      .sample (sample),
      .load   (load),
      .q      (btn[c])
    );
  end

  assign buttons = btn;
endmodule

// File: tb/tb_nes_pad_scanner.sv
// Directed bench for nes_pad_scanner: an 8-bit two-pad instance and a 16-bit single-pad instance share clock, reset and enable.
module tb_nes_pad_scanner;
  logic        CLK = 1'b0, reset_n = 1'b0, en = 1'b1, start_a = 1'b0, start_b = 1'b0;
  logic [1:0]  d_a;
  logic [0:0]  d_b;
  logic        srl_a, srclk_a, valid_a, busy_a;
  logic        srl_b, srclk_b, valid_b, busy_b;
  logic [15:0] btn_a, btn_b;
  logic [7:0]  pat0 = 8'h5A, pat1 = 8'h81;
  logic [15:0] pat_b = 16'h0000;
  logic [4:0]  idx_a = '0, idx_b = '0;
  int          checks = 0, errors = 0;

  always #5 CLK = ~CLK;

  // Pad models: latch reloads, each SRCLK rise advances one bit; past the end the line reads released.
  always @(posedge srl_a or posedge srclk_a) if (srl_a) idx_a <= '0; else idx_a <= idx_a + 5'd1;
  always @(posedge srl_b or posedge srclk_b) if (srl_b) idx_b <= '0; else idx_b <= idx_b + 5'd1;
  assign d_a[0] = (idx_a < 5'd8) ? ~pat0[idx_a[2:0]] : 1'b1;
  assign d_a[1] = (idx_a < 5'd8) ? ~pat1[idx_a[2:0]] : 1'b1;
  assign d_b[0] = (idx_b < 5'd16) ? ~pat_b[idx_b[3:0]] : 1'b1;

  nes_pad_scanner #(.CHANNELS(2), .BITS(8), .HALF_DIV(4), .POLL_DIV(200)) u_a (
    .CLK(CLK), .reset_n(reset_n), .en(en), .start(start_a), .D(d_a),
    .SRL(srl_a), .SRCLK(srclk_a), .buttons(btn_a), .valid(valid_a), .busy(busy_a));

  nes_pad_scanner #(.CHANNELS(1), .BITS(16), .HALF_DIV(4), .POLL_DIV(200)) u_b (
    .CLK(CLK), .reset_n(reset_n), .en(en), .start(start_b), .D(d_b),
    .SRL(srl_b), .SRCLK(srclk_b), .buttons(btn_b), .valid(valid_b), .busy(busy_b));

  task automatic test_reset();
    repeat (3) @(negedge CLK);
    checks++; if ({srl_a, srclk_a, valid_a, busy_a} !== 4'b0) begin errors++; $display("FAIL reset_ctrl got %b want 0000", {srl_a, srclk_a, valid_a, busy_a}); end
    checks++; if (btn_a !== 16'h0) begin errors++; $display("FAIL reset_buttons got %h want 0000", btn_a); end
    checks++; if ({busy_b, btn_b} !== 17'h0) begin errors++; $display("FAIL reset_b got %h want 0", {busy_b, btn_b}); end
    reset_n = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_single_scan();
    int srl_first = 0, srl_last = 0, pulses = 0, hi_len = 0, bad_len = 0, vcyc = 0, vcount = 0;
    logic prev = 1'b0;
    logic [15:0] btn_early = 16'hxxxx;
    @(negedge CLK); start_a = 1'b1;
    @(negedge CLK); start_a = 1'b0;
    for (int n = 1; n <= 80; n++) begin
      if (srl_a) begin if (srl_first == 0) srl_first = n; srl_last = n; end
      if (srclk_a && !prev) begin pulses++; hi_len = 1; end
      else if (srclk_a) hi_len++;
      else if (prev && hi_len != 4) bad_len++;
      prev = srclk_a;
      if (valid_a) begin vcount++; vcyc = n; end
      if (n == 64) btn_early = btn_a;
      @(negedge CLK);
    end
    checks++; if (srl_first != 1 || srl_last != 8) begin errors++; $display("FAIL scan_srl got %0d..%0d want 1..8", srl_first, srl_last); end
    checks++; if (pulses != 7) begin errors++; $display("FAIL scan_pulses got %0d want 7", pulses); end
    checks++; if (bad_len != 0) begin errors++; $display("FAIL scan_pulse_len got %0d bad want 0", bad_len); end
    checks++; if (vcount != 1 || vcyc != 65) begin errors++; $display("FAIL scan_valid got %0d@%0d want 1@65", vcount, vcyc); end
    checks++; if (btn_early !== 16'h0000) begin errors++; $display("FAIL scan_no_partial got %h want 0000", btn_early); end
    checks++; if (btn_a !== 16'h815A) begin errors++; $display("FAIL scan_buttons got %h want 815a", btn_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL scan_busy_end got %b want 0", busy_a); end
  endtask

  task automatic test_busy_start();
    int vcyc = 0, vcount = 0;
    pat0 = 8'h3C; pat1 = 8'h00;
    @(negedge CLK); start_a = 1'b1;
    @(negedge CLK); start_a = 1'b0;
    for (int n = 1; n <= 150; n++) begin
      start_a = (n == 20 || n == 65);
      if (valid_a) begin vcount++; vcyc = n; end
      @(negedge CLK);
    end
    start_a = 1'b0;
    checks++; if (vcount != 1 || vcyc != 65) begin errors++; $display("FAIL busy_start valid got %0d@%0d want 1@65", vcount, vcyc); end
    checks++; if (btn_a !== 16'h003C) begin errors++; $display("FAIL busy_start buttons got %h want 003c", btn_a); end
  endtask

  task automatic test_enable_freeze();
    int vcyc = 0, vcount = 0, drops = 0, pulses = 0;
    logic prev = 1'b0;
    pat0 = 8'hA5; pat1 = 8'h7E;
    @(negedge CLK); start_a = 1'b1;
    @(negedge CLK); start_a = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      if (n >= 11 && n <= 20 && !srclk_a) drops++;
      if (srclk_a && !prev) pulses++;
      prev = srclk_a;
      if (valid_a) begin vcount++; vcyc = n; end
      en = !(n >= 10 && n <= 19);
      @(negedge CLK);
    end
    en = 1'b1;
    checks++; if (drops != 0) begin errors++; $display("FAIL en_srclk_hold got %0d low cycles want 0", drops); end
    checks++; if (pulses != 7) begin errors++; $display("FAIL en_pulses got %0d want 7", pulses); end
    checks++; if (vcount != 1 || vcyc != 75) begin errors++; $display("FAIL en_valid got %0d@%0d want 1@75", vcount, vcyc); end
    checks++; if (btn_a !== 16'h7EA5) begin errors++; $display("FAIL en_buttons got %h want 7ea5", btn_a); end
  endtask

  task automatic test_bits16();
    logic [15:0] pats [2];
    pats[0] = 16'h1234; pats[1] = 16'h0000;
    for (int p = 0; p < 2; p++) begin
      int vcyc = 0, vcount = 0;
      pat_b = pats[p];
      @(negedge CLK); start_b = 1'b1;
      @(negedge CLK); start_b = 1'b0;
      for (int n = 1; n <= 140; n++) begin
        if (valid_b) begin vcount++; vcyc = n; end
        @(negedge CLK);
      end
      checks++; if (vcount != 1 || vcyc != 129) begin errors++; $display("FAIL b16_valid[%0d] got %0d@%0d want 1@129", p, vcount, vcyc); end
      checks++; if (btn_b !== pats[p]) begin errors++; $display("FAIL b16_buttons[%0d] got %h want %h", p, btn_b, pats[p]); end
    end
  endtask

  task automatic test_reset_mid_scan();
    int vcount = 0;
    @(negedge CLK); start_a = 1'b1;
    @(negedge CLK); start_a = 1'b0;
    repeat (33) @(negedge CLK);
    checks++; if ({srclk_a, busy_a} !== 2'b11) begin errors++; $display("FAIL rst_mid_pre got %b want 11", {srclk_a, busy_a}); end
    reset_n = 1'b0;
    #1;
    checks++; if ({srl_a, srclk_a, valid_a, busy_a} !== 4'b0) begin errors++; $display("FAIL rst_mid_ctrl got %b want 0000", {srl_a, srclk_a, valid_a, busy_a}); end
    checks++; if (btn_a !== 16'h0) begin errors++; $display("FAIL rst_mid_buttons got %h want 0000", btn_a); end
    @(negedge CLK); reset_n = 1'b1;
    for (int n = 0; n < 100; n++) begin
      if (valid_a || busy_a || srl_a || srclk_a) vcount++;
      @(negedge CLK);
    end
    checks++; if (vcount != 0) begin errors++; $display("FAIL rst_mid_idle got %0d active cycles want 0", vcount); end
  endtask

  task automatic test_autopoll();
    int vcount = 0, last = 0, bad_gap = 0;
    for (int n = 1; n <= 1000; n++) begin
      if (valid_a) begin
        if (last != 0 && n - last != 200) bad_gap++;
        last = n; vcount++;
      end
      @(negedge CLK);
    end
`ifdef NES_AUTOPOLL_EN
    checks++; if (vcount != 5 || bad_gap != 0) begin errors++; $display("FAIL autopoll got %0d strobes %0d bad gaps want 5/0", vcount, bad_gap); end
`else
    checks++; if (vcount != 0) begin errors++; $display("FAIL no_autopoll got %0d strobes want 0 (gaps %0d)", vcount, bad_gap); end
`endif
  endtask

  initial begin
    test_reset();
    test_single_scan();
    test_busy_start();
    test_enable_freeze();
    test_bits16();
    test_reset_mid_scan();
    test_autopoll();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule

// File: doc/nes_pad_scanner.md
# nes_pad_scanner

Multi-channel serial game-pad scanner generating the latch and shift-clock waveforms for NES/SNES-style controllers from the system clock, capturing all pads in parallel. Replaces the externally-clocked single-pad driver: one internal timebase, per-channel input synchronizers, configurable bit count and pad count, and a one-cycle `valid` strobe when a fresh snapshot is published. Sits between the controller connector pins and the game logic's input register.

## Interface
- `CHANNELS`, 2, number of pads scanned in parallel (1..4).
- `BITS`, 8, bits per pad (8 = NES, 16 = SNES).
- `HALF_DIV`, 300, system-clock cycles per half-period tick (300 = 6 us at 50 MHz).
- `POLL_DIV`, 833333, cycles between automatic scan starts (used only with `NES_AUTOPOLL_EN`).
- `CLK`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  global enable; low freezes all state and counters.
- `start`  in  1  request a scan; sampled only in IDLE.
- `D`  in  `CHANNELS`  serial data from pads, active-low (0 = pressed).
- `SRL`  out  1  latch to pads, active-high.
- `SRCLK`  out  1  shift clock to pads, idles low; pads shift on rising edge.
- `buttons`  out  `CHANNELS*BITS`  snapshot; channel c at `[c*BITS +: BITS]`, bit k = k-th shifted bit, 1 = pressed.
- `valid`  out  1  one-cycle strobe when `buttons` updates.
- `busy`  out  1  high while a scan is in progress.

## Operation
- `D` passes through a 2-flop synchronizer per channel before use; sampled values are inverted into the shift registers.
- States: IDLE, LATCH, CLK_HI, CLK_LO, DONE.
- IDLE: `SRL`=0, `SRCLK`=0, `busy`=0. `start`=1 (or autopoll trigger) -> LATCH, tick counter and bit counter cleared.
- LATCH: `SRL`=1 for 2 ticks. On its final cycle bit 0 of every channel is sampled. -> CLK_HI if `BITS`>1, else DONE.
- CLK_HI: `SRCLK`=1 for 1 tick; bit k sampled on final cycle; bit counter increments. -> CLK_LO.
- CLK_LO: `SRCLK`=0 for 1 tick. -> CLK_HI if fewer than `BITS` bits sampled, else DONE.
- DONE (one cycle): per-channel shift registers copied to `buttons`, `valid`=1. -> IDLE.
- Shift registers shift toward LSB so bit 0 lands in `buttons` bit 0.
- `buttons` holds its value between scans; never partially updated.
- `busy`=1 in LATCH, CLK_HI, CLK_LO, DONE.

## Timing
- Reset values: `SRL`=0, `SRCLK`=0, `buttons`=0, `valid`=0, `busy`=0, state IDLE, synchronizers 0 (reset takes effect immediately, asynchronously).
- Tick counter counts 0..`HALF_DIV`-1; phase ends on count `HALF_DIV`-1.
- Scan length: (2 + 2*(`BITS`-1)) * `HALF_DIV` cycles after the start edge, plus 1 DONE cycle. `start` at edge t -> `SRL` rises t+1 -> `valid` high during cycle t+1+(2*`BITS`)*`HALF_DIV`.
- `start` while `busy` is ignored (not queued).
- Pad data observed with 2-cycle synchronizer latency; sample points are ≥`HALF_DIV`-1 cycles after each `SRCLK` rise, so synchronizer delay never affects value.
- `en`=0: state, counters, outputs frozen; `valid` forced 0 while low and not re-emitted on resume; scan continues where it stopped.
- `reset_n` low mid-scan: outputs return to reset values at once; partial data discarded.
- All outputs registered; no combinational path from inputs to outputs.

## Configuration
- `NES_AUTOPOLL_EN` defined: free-running counter (0..`POLL_DIV`-1) issues an internal start on wrap; counter runs in all states, gated by `en`; wrap while busy is dropped. `start` still also works. `POLL_DIV` must exceed scan length.
- Not defined: counter absent; scans occur only on `start`.

## Test plan
- Reset: drive `reset_n`=0 mid-scan -> `SRL`=0, `SRCLK`=0, `buttons`=0, `busy`=0 same cycle; after release, IDLE.
- Single scan, `CHANNELS`=2, `BITS`=8, `HALF_DIV`=4, pad0 model presents 0x5A pressed, pad1 0x81: `start` at t -> `SRL` high t+1..t+8, 7 `SRCLK` pulses 4 cycles high, `valid` at t+65, `buttons`=0x815A.
- `start` asserted while `busy` -> no extra scan, exactly one `valid` per accepted start.
- `en` low for 10 cycles during CLK_HI -> `SRCLK` stays high, `valid` delayed by exactly 10 cycles, data unchanged.
- `BITS`=16, one channel, pad presents 0xFFFF released -> `buttons`=0x0000, `valid` at t+1+32*`HALF_DIV`.
- With `NES_AUTOPOLL_EN`, `POLL_DIV`=200, `HALF_DIV`=4: `valid` strobes every 200 cycles with no `start`; without macro, no scan occurs in 1000 idle cycles.
